// File: rtl/aes_pkg.sv
// =============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 key-schedule types, constants, S-box and xtime.
// Revision    : 1.0
// =============================================================================
`default_nettype none

package aes_pkg;

    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [0:255][7:0] C_SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return C_SBOX[b];
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes128_key_round.sv
// =============================================================================
// Module      : aes128_key_round
// Description : One combinational AES-128 key-expansion step (g_function + XOR chain).
// Revision    : 1.0
// =============================================================================
`default_nettype none

module aes128_g_function
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_rcon,
    output logic [31:0] o_word
);

    logic [31:0] w_rot;
    logic [31:0] w_sub;

    assign w_rot = {i_word[23:0], i_word[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        assign w_sub[gi*8 +: 8] = sbox(w_rot[gi*8 +: 8]);
    end

    assign o_word = w_sub ^ i_rcon;

endmodule

module aes128_key_round
    import aes_pkg::*;
(
    input  logic [127:0] i_key,
    input  logic [31:0]  i_rcon,
    output logic [127:0] o_next_key
);

    logic [31:0] w_t;
    logic [31:0] w_w4;
    logic [31:0] w_w5;
    logic [31:0] w_w6;
    logic [31:0] w_w7;

    aes128_g_function u_g (
        .i_word (i_key[31:0]),
        .i_rcon (i_rcon),
        .o_word (w_t)
    );

    assign w_w4       = i_key[127:96] ^ w_t;
    assign w_w5       = w_w4 ^ i_key[95:64];
    assign w_w6       = w_w5 ^ i_key[63:32];
    assign w_w7       = w_w6 ^ i_key[31:0];
    assign o_next_key = {w_w4, w_w5, w_w6, w_w7};

endmodule

`default_nettype wire

// File: rtl/aes128_key_sched.sv
// =============================================================================
// Module      : aes128_key_sched
// Description : Sequential AES-128 key-expansion controller, one round key per handshake.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module aes128_key_sched
    import aes_pkg::*;
#(
    parameter int ROUNDS = AES_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         abort,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] round_key,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] C_LAST = 4'(ROUNDS);

    state_t       r_state;
    state_t       w_next_state;
    logic [127:0] r_w;
    logic [7:0]   r_rcon;
    logic [3:0]   r_round;
    logic [127:0] w_next_key;
    logic         w_hs;
    logic         w_last;

    assign w_hs   = (r_state == EMIT) && rk_ready;
    assign w_last = (r_round == C_LAST);

    aes128_key_round u_round (
        .i_key      (r_w),
        .i_rcon     ({r_rcon, 24'h0}),
        .o_next_key (w_next_key)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_next_state = EMIT;
                EMIT:    if (w_hs && w_last) w_next_state = FIN;
                FIN:     w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        rk_valid  = (r_state == EMIT);
        busy      = (r_state != IDLE);
        done      = (r_state == FIN);
        round_key = r_w;
        rk_round  = r_round;
    end

    // Key register advances only on a non-final handshake, so the last key holds through FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w     <= '0;
            r_rcon  <= RCON_INIT;
            r_round <= '0;
        end else if (abort) begin
            if (r_state != IDLE) begin
                r_w     <= '0;
                r_rcon  <= RCON_INIT;
                r_round <= '0;
            end
        end else if (r_state == IDLE && start) begin
            r_w     <= key_in;
            r_rcon  <= RCON_INIT;
            r_round <= '0;
        end else if (w_hs && !w_last) begin
            r_w     <= w_next_key;
            r_rcon  <= xtime(r_rcon);
            r_round <= r_round + 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes128_key_sched.sv
// =============================================================================
// Module      : tb_aes128_key_sched
// Description : Self-checking bench with a word-array FIPS-197 key expansion model.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module tb_aes128_key_sched;

    localparam int ROUNDS = 10;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         abort;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    int n_checks;
    int n_pass;

    logic [7:0]   sbox_m [0:255];
    logic [127:0] exp_rk [0:10];
    logic [127:0] got_rk [0:10];
    logic [7:0]   inv_v;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    typedef struct {
        logic [127:0] key;
        bit           rnd;
        bit           has_kat;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;

    vec_t vecs [0:5];

    aes128_key_sched #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .abort     (abort),
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .rk_round  (rk_round),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // FIPS-197 word-indexed expansion: w[i] = w[i-4] ^ f(w[i-1]).
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_exp(input logic [127:0] key, input bit rnd, input int start_at,
                           input int abort_at, input int rst_at);
        int idx;
        int cyc;
        bit inj;
        model_expand(key);
        key_in = key;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        key_in = ~key;
        idx = 0;
        cyc = 0;
        inj = 1'b0;
        while (idx <= ROUNDS && cyc < 400) begin
            start = 1'b0;
            if (!rk_valid) begin
                chk("valid_drop", 128'(rk_valid), 128'd1);
                rk_ready = 1'b0;
                return;
            end
            chk("rk_round", 128'(rk_round), 128'(idx));
            chk("round_key", round_key, exp_rk[idx]);
            got_rk[idx] = round_key;
            if (idx == abort_at) begin
                abort    = 1'b1;
                rk_ready = 1'b0;
                tick;
                abort = 1'b0;
                chk("abort_valid", 128'(rk_valid), 128'd0);
                chk("abort_busy", 128'(busy), 128'd0);
                chk("abort_done", 128'(done), 128'd0);
                chk("abort_key", round_key, 128'd0);
                tick;
                chk("abort_done2", 128'(done), 128'd0);
                return;
            end
            if (idx == rst_at) begin
                rk_ready = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("arst_valid", 128'(rk_valid), 128'd0);
                chk("arst_key", round_key, 128'd0);
                chk("arst_round", 128'(rk_round), 128'd0);
                chk("arst_busy", 128'(busy), 128'd0);
                @(posedge clk);
                #3 rst = 1'b0;
                tick;
                chk("arst_idle_busy", 128'(busy), 128'd0);
                chk("arst_idle_valid", 128'(rk_valid), 128'd0);
                return;
            end
            if (idx == start_at && !inj) begin
                start = 1'b1;
                inj   = 1'b1;
            end
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_ready) idx++;
            tick;
            cyc++;
        end
        rk_ready = 1'b0;
        if (cyc >= 400) begin
            chk("timeout", 128'(cyc), 128'd0);
            return;
        end
        if (!rnd) chk("cycles", 128'(cyc), 128'(ROUNDS + 1));
        chk("done_pulse", 128'(done), 128'd1);
        chk("fin_valid", 128'(rk_valid), 128'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("done_single", 128'(done), 128'd0);
        chk("fin_start_ignored", 128'(busy), 128'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;

        for (int x = 0; x < 256; x++) begin
            inv_v = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv_v = 8'(y);
            sbox_m[x] = inv_v ^ rotl8(inv_v, 1) ^ rotl8(inv_v, 2) ^ rotl8(inv_v, 3)
                        ^ rotl8(inv_v, 4) ^ 8'h63;
        end

        vecs[0] = '{FIPS_KEY, 1'b0, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{FIPS_KEY, 1'b1, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[2] = '{128'h0, 1'b0, 1'b1, 128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        for (int v = 3; v < 6; v++)
            vecs[v] = '{{$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 128'h0, 128'h0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 128'(rk_valid), 128'd0);
        chk("rst_key", round_key, 128'd0);
        chk("rst_round", 128'(rk_round), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        rst = 1'b0;
        tick;

        start  = 1'b1;
        abort  = 1'b1;
        key_in = FIPS_KEY;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 128'(busy), 128'd0);

        for (int v = 0; v < 6; v++) begin
            run_exp(vecs[v].key, vecs[v].rnd, -1, -1, -1);
            chk("kat_rk0", got_rk[0], vecs[v].key);
            if (vecs[v].has_kat) begin
                chk("kat_rk1", got_rk[1], vecs[v].rk1);
                chk("kat_rk10", got_rk[10], vecs[v].rk10);
            end
        end

        run_exp(FIPS_KEY, 1'b1, 4, -1, -1);
        chk("restart_ignored_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_exp(128'h0, 1'b0, -1, 6, -1);
        run_exp(FIPS_KEY, 1'b0, -1, -1, -1);
        chk("after_abort_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);

        run_exp(FIPS_KEY, 1'b0, -1, -1, 3);
        run_exp(FIPS_KEY, 1'b1, -1, -1, -1);
        chk("after_rst_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
